// File: rtl/memory_stage_if.sv
// Execute-to-memory and memory-to-writeback signal bundle for the Y86-64 memory stage.
// master drives instructions and observes results; slave is the memory stage itself.
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              in_valid;
    logic [3:0]        icode;
    logic [2:0]        stat_in;
    logic [ADDR_W-1:0] valE;
    logic [ADDR_W-1:0] valA;
    logic [ADDR_W-1:0] valP;
    logic [3:0]        dstE;
    logic [3:0]        dstM;

    logic              out_valid;
    logic [3:0]        out_icode;
    logic [2:0]        out_stat;
    logic [ADDR_W-1:0] out_valE;
    logic [ADDR_W-1:0] out_valM;
    logic [3:0]        out_dstE;
    logic [3:0]        out_dstM;
    logic              halted;

    modport master (
        output in_valid, icode, stat_in, valE, valA, valP, dstE, dstM,
        input  out_valid, out_icode, out_stat, out_valE, out_valM, out_dstE, out_dstM, halted
    );

    modport slave (
        input  in_valid, icode, stat_in, valE, valA, valP, dstE, dstM,
        output out_valid, out_icode, out_stat, out_valE, out_valM, out_dstE, out_dstM, halted
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed data memory, dmem_error/stat generation, sticky HALTED.
// Optional DMEM_DEBUG_PORT_EN adds a combinational dbg_addr/dbg_data memory peek port.
module memory_stage #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [ADDR_W-1:0] dbg_data,
`endif
    memory_stage_if.slave     bus
);
    localparam int unsigned       IDX_W    = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 8);
    localparam logic [2:0]        StatAok  = 3'd1;
    localparam logic [2:0]        StatAdr  = 3'd3;

    typedef enum logic {StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_icode_q, out_icode_d;
    logic [2:0]        out_stat_q, out_stat_d;
    logic [ADDR_W-1:0] out_valE_q, out_valE_d;
    logic [ADDR_W-1:0] out_valM_q, out_valM_d;
    logic [3:0]        out_dstE_q, out_dstE_d;
    logic [3:0]        out_dstM_q, out_dstM_d;

    logic [7:0]        mem [MEM_BYTES];

    logic              is_read, is_write, stat_aok, dmem_error, we;
    logic [ADDR_W-1:0] acc_addr, wr_data, rd_word;
    logic [IDX_W-1:0]  acc_idx;
    logic [2:0]        final_stat;

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        acc_addr = bus.valE;
        wr_data  = bus.valA;
        case (bus.icode)
            4'h4, 4'hA: is_write = 1'b1;
            4'h8: begin
                is_write = 1'b1;
                wr_data  = bus.valP;
            end
            4'h5:       is_read = 1'b1;
            4'h9, 4'hB: begin
                is_read  = 1'b1;
                acc_addr = bus.valA;
            end
            default: ;
        endcase
    end

    // A non-AOK incoming stat means no access is attempted, so it can never raise ADR.
    assign stat_aok   = (bus.stat_in == StatAok);
    assign dmem_error = (is_read || is_write) && stat_aok && (acc_addr > ADDR_MAX);
    assign final_stat = !stat_aok ? bus.stat_in : (dmem_error ? StatAdr : StatAok);
    assign acc_idx    = dmem_error ? '0 : acc_addr[IDX_W-1:0];
    assign we = (state_q == StRun) && bus.in_valid && stat_aok && is_write && !dmem_error && rst_n;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) begin
            rd_word[8*k +: 8] = mem[acc_idx + IDX_W'(k)];
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[acc_idx + IDX_W'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_icode_d = out_icode_q;
        out_stat_d  = out_stat_q;
        out_valE_d  = out_valE_q;
        out_valM_d  = out_valM_q;
        out_dstE_d  = out_dstE_q;
        out_dstM_d  = out_dstM_q;
        if (state_q == StRun && bus.in_valid) begin
            out_valid_d = 1'b1;
            out_icode_d = bus.icode;
            out_stat_d  = final_stat;
            out_valE_d  = bus.valE;
            out_valM_d  = (is_read && stat_aok && !dmem_error) ? rd_word : '0;
            out_dstE_d  = (final_stat == StatAok) ? bus.dstE : 4'hF;
            out_dstM_d  = (final_stat == StatAok) ? bus.dstM : 4'hF;
            if (final_stat != StatAok) begin
                state_d = StHalted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_stat_q  <= StatAok;
            out_valE_q  <= '0;
            out_valM_q  <= '0;
            out_dstE_q  <= 4'hF;
            out_dstM_q  <= 4'hF;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_stat_q  <= out_stat_d;
            out_valE_q  <= out_valE_d;
            out_valM_q  <= out_valM_d;
            out_dstE_q  <= out_dstE_d;
            out_dstM_q  <= out_dstM_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.out_stat  = out_stat_q;
    assign bus.out_valE  = out_valE_q;
    assign bus.out_valM  = out_valM_q;
    assign bus.out_dstE  = out_dstE_q;
    assign bus.out_dstM  = out_dstM_q;
    assign bus.halted    = (state_q == StHalted);

`ifdef DMEM_DEBUG_PORT_EN
    logic [IDX_W-1:0] dbg_idx;

    always_comb begin
        dbg_idx  = (dbg_addr > ADDR_MAX) ? '0 : dbg_addr[IDX_W-1:0];
        dbg_data = '0;
        if (dbg_addr <= ADDR_MAX) begin
            for (int k = 0; k < 8; k++) begin
                dbg_data[8*k +: 8] = mem[dbg_idx + IDX_W'(k)];
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed instructions push expected retirements,
// a negedge monitor pops and compares them whenever out_valid is seen.
module tb_memory_stage;
    localparam int unsigned MemBytes = 4096;

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    memory_stage_if #(.ADDR_W(64)) bus ();

`ifdef DMEM_DEBUG_PORT_EN
    logic [63:0] dbg_addr;
    logic [63:0] dbg_data;
`endif

    memory_stage #(
        .MEM_BYTES(MemBytes),
        .ADDR_W   (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DMEM_DEBUG_PORT_EN
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
`endif
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got out_valid=1 icode=0x%0h expected out_valid=0",
                         bus.out_icode);
            end else begin
                e = sb_q.pop_front();
                chk("out_icode", 64'(bus.out_icode), 64'(e.icode));
                chk("out_stat", 64'(bus.out_stat), 64'(e.stat));
                chk("out_valE", bus.out_valE, e.valE);
                chk("out_valM", bus.out_valM, e.valM);
                chk("out_dstE", 64'(bus.out_dstE), 64'(e.dstE));
                chk("out_dstM", 64'(bus.out_dstM), 64'(e.dstM));
            end
        end
    end

    task automatic send(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                        input logic [63:0] va, input logic [63:0] vp, input logic [3:0] de,
                        input logic [3:0] dm, input logic push, input logic [2:0] xst,
                        input logic [63:0] xvm, input logic [3:0] xde, input logic [3:0] xdm);
        bus.in_valid = 1'b1;
        bus.icode    = ic;
        bus.stat_in  = st;
        bus.valE     = ve;
        bus.valA     = va;
        bus.valP     = vp;
        bus.dstE     = de;
        bus.dstM     = dm;
        if (push) sb_q.push_back('{ic, xst, ve, xvm, xde, xdm});
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] data);
        send(4'h4, 3'd1, addr, data, 64'h0, 4'hF, 4'hF, 1'b1, 3'd1, 64'h0, 4'hF, 4'hF);
    endtask

    task automatic rd(input logic [63:0] addr, input logic [3:0] dm, input logic [63:0] exp);
        send(4'h5, 3'd1, addr, 64'h0, 64'h0, 4'hF, dm, 1'b1, 3'd1, exp, 4'hF, dm);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
        chk({tag, "_out_icode"}, 64'(bus.out_icode), 64'h0);
        chk({tag, "_out_stat"}, 64'(bus.out_stat), 64'h1);
        chk({tag, "_out_valE"}, bus.out_valE, 64'h0);
        chk({tag, "_out_valM"}, bus.out_valM, 64'h0);
        chk({tag, "_out_dstE"}, 64'(bus.out_dstE), 64'hF);
        chk({tag, "_out_dstM"}, 64'(bus.out_dstM), 64'hF);
        chk({tag, "_halted"}, 64'(bus.halted), 64'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.icode    = 4'h0;
        bus.stat_in  = 3'd1;
        bus.valE     = '0;
        bus.valA     = '0;
        bus.valP     = '0;
        bus.dstE     = 4'hF;
        bus.dstM     = 4'hF;
`ifdef DMEM_DEBUG_PORT_EN
        dbg_addr = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_init");
        rst_n = 1'b1;

        // Known contents for later reset-free readbacks.
        wr(64'h0, 64'h5A5A_5A5A_5A5A_5A5A);
        wr(64'h300, 64'h1111);
        wr(64'h400, 64'h4444);

        // Back-to-back write then read of the same word.
        wr(64'h100, 64'h1122_3344_5566_7788);
        rd(64'h100, 4'h3, 64'h1122_3344_5566_7788);
`ifdef DMEM_DEBUG_PORT_EN
        dbg_addr = 64'h100;
        #1;
        chk("dbg_byte0", 64'(dbg_data[7:0]), 64'h88);
        dbg_addr = 64'd4089;
        #1;
        chk("dbg_oob", dbg_data, 64'h0);
`endif

        // call/ret and pushq/popq
        send(4'h8, 3'd1, 64'h200, 64'h0, 64'h3C, 4'h4, 4'hF, 1'b1, 3'd1, 64'h0, 4'h4, 4'hF);
        send(4'h9, 3'd1, 64'h208, 64'h200, 64'h0, 4'h4, 4'hF, 1'b1, 3'd1, 64'h3C, 4'h4, 4'hF);
        send(4'hA, 3'd1, 64'h1F8, 64'hDEAD, 64'h0, 4'h4, 4'hF, 1'b1, 3'd1, 64'h0, 4'h4, 4'hF);
        send(4'hB, 3'd1, 64'h200, 64'h1F8, 64'h0, 4'h4, 4'h5, 1'b1, 3'd1, 64'hDEAD, 4'h4, 4'h5);

        // Unaligned overlapping write: bytes 0x100..0x102 keep 88 77 66.
        wr(64'h103, 64'hAABB_CCDD_EEFF_0011);
        rd(64'h100, 4'h3, 64'hDDEE_FF00_1166_7788);

        // Non-memory instruction, then a bubble that must hold outputs.
        send(4'h3, 3'd1, 64'h55, 64'h0, 64'h0, 4'h2, 4'hF, 1'b1, 3'd1, 64'h0, 4'h2, 4'hF);
        idle();
        chk("bubble_out_valid", 64'(bus.out_valid), 64'h0);
        chk("bubble_hold_valE", bus.out_valE, 64'h55);
        chk("bubble_hold_dstE", 64'(bus.out_dstE), 64'h2);

        // Highest legal word address.
        wr(64'd4088, 64'h0123_4567_89AB_CDEF);
        rd(64'd4088, 4'h6, 64'h0123_4567_89AB_CDEF);

        // Address error halts; following writes are ignored.
        send(4'h5, 3'd1, 64'd4089, 64'h0, 64'h0, 4'hF, 4'h3, 1'b1, 3'd3, 64'h0, 4'hF, 4'hF);
        chk("adr_halted", 64'(bus.halted), 64'h1);
        send(4'h4, 3'd1, 64'h0, 64'hBAD, 64'h0, 4'hF, 4'hF, 1'b0, 3'd1, 64'h0, 4'hF, 4'hF);
        chk("halted_no_retire", 64'(bus.out_valid), 64'h0);
        chk("halted_hold_stat", 64'(bus.out_stat), 64'h3);
        do_reset("rst_after_adr");
        rd(64'h0, 4'h1, 64'h5A5A_5A5A_5A5A_5A5A);

        // Huge address must not wrap into range.
        send(4'h4, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h99, 64'h0, 4'hF, 4'hF, 1'b1, 3'd3, 64'h0,
             4'hF, 4'hF);
        chk("wrap_halted", 64'(bus.halted), 64'h1);
        do_reset("rst_after_wrap");

        // HLT from upstream: no write, dst forced off, single retirement.
        send(4'hA, 3'd2, 64'h300, 64'h77, 64'h0, 4'h4, 4'hF, 1'b1, 3'd2, 64'h0, 4'hF, 4'hF);
        chk("hlt_halted", 64'(bus.halted), 64'h1);
        send(4'hA, 3'd1, 64'h300, 64'h88, 64'h0, 4'h4, 4'hF, 1'b0, 3'd1, 64'h0, 4'hF, 4'hF);
        chk("hlt_valid_low1", 64'(bus.out_valid), 64'h0);
        send(4'h4, 3'd1, 64'h300, 64'h99, 64'h0, 4'hF, 4'hF, 1'b0, 3'd1, 64'h0, 4'hF, 4'hF);
        chk("hlt_valid_low2", 64'(bus.out_valid), 64'h0);
        do_reset("rst_after_hlt");
        rd(64'h300, 4'h1, 64'h1111);

        // INS passes through even with an out-of-range address.
        send(4'h5, 3'd4, 64'd4089, 64'h0, 64'h0, 4'hF, 4'h3, 1'b1, 3'd4, 64'h0, 4'hF, 4'hF);
        do_reset("rst_after_ins");

        // Write presented while reset is asserted must be suppressed.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.icode    = 4'h4;
        bus.stat_in  = 3'd1;
        bus.valE     = 64'h400;
        bus.valA     = 64'hBEEF;
        @(posedge clk);
        #1;
        check_reset("rst_midop");
        rst_n = 1'b1;
        rd(64'h400, 4'h1, 64'h4444);
        idle();
        idle();

        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
